// File: rtl/mult_div_unit_pkg.sv
// Shared definitions for the iterative multiply/divide unit: FSM states and op encodings.
package mult_div_unit_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_FIX  = 2'd2
    } mdu_state_e;

    localparam logic OP_MUL = 1'b0;
    localparam logic OP_DIV = 1'b1;

endpackage

// File: rtl/mult_div_unit_cneg.sv
// Conditional two's-complement negator: dout = en ? -din : din.
module mdu_cneg #(
    parameter int WIDTH = 32
) (
    input  logic             en,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    assign dout = en ? (~din + WIDTH'(1)) : din;

endmodule

// File: rtl/mult_div_unit.sv
// Iterative radix-2 multiply/divide unit with HI/LO result registers.
// Divide path is built only when MDU_DIV_EN is defined; otherwise every op multiplies.
module mult_div_unit
    import mult_div_unit_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             op_div,
    input  logic             op_sign,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    input  logic             abort,
    input  logic             hi_we,
    input  logic             lo_we,
    input  logic [WIDTH-1:0] wr_data,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CW = $clog2(WIDTH) + 1;
    localparam int AW = 2 * WIDTH + 1;
    localparam logic [CW-1:0] LAST_STEP = CW'(WIDTH);

    mdu_state_e       state_q, state_d;
    logic [CW-1:0]    count_q, count_d;
    logic [AW-1:0]    acc_q, acc_d;
    logic [WIDTH-1:0] opnd_q, opnd_d;
    logic             neg_lo_q, neg_lo_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;

    logic             a_neg, b_neg;
    logic [WIDTH-1:0] a_mag, b_mag;
    logic [WIDTH:0]   add_sum;
    logic [AW-1:0]    mul_next;
    logic [2*WIDTH-1:0] prod_fix;

    assign a_neg = op_sign & a_in[WIDTH-1];
    assign b_neg = op_sign & b_in[WIDTH-1];

    mdu_cneg #(.WIDTH(WIDTH)) u_mag_a (.en(a_neg), .din(a_in), .dout(a_mag));
    mdu_cneg #(.WIDTH(WIDTH)) u_mag_b (.en(b_neg), .din(b_in), .dout(b_mag));
    mdu_cneg #(.WIDTH(2*WIDTH)) u_fix_prod (
        .en(neg_lo_q), .din(acc_q[2*WIDTH-1:0]), .dout(prod_fix)
    );

    // Shift-add: acc = {carry, partial product, remaining multiplier bits}.
    assign add_sum  = acc_q[AW-1:WIDTH] + (acc_q[0] ? {1'b0, opnd_q} : '0);
    assign mul_next = {1'b0, add_sum, acc_q[WIDTH-1:1]};

`ifdef MDU_DIV_EN
    localparam logic [WIDTH-1:0] DIVZERO_QUOT = '1;

    logic             op_div_q, op_div_d;
    logic             neg_hi_q, neg_hi_d;
    logic             dz_q, dz_d;
    logic [WIDTH-1:0] a_raw_q, a_raw_d;
    logic [AW-1:0]    shifted, div_next;
    logic [WIDTH:0]   diff;
    logic             fits;
    logic [WIDTH-1:0] quot_fix, rem_fix;

    // Restoring divide: acc = {partial remainder, dividend bits / quotient bits}.
    assign shifted  = {acc_q[AW-2:0], 1'b0};
    assign diff     = shifted[AW-1:WIDTH] - {1'b0, opnd_q};
    assign fits     = shifted[AW-1:WIDTH] >= {1'b0, opnd_q};
    assign div_next = fits ? {diff, shifted[WIDTH-1:1], 1'b1} : shifted;

    mdu_cneg #(.WIDTH(WIDTH)) u_fix_quot (
        .en(neg_lo_q), .din(acc_q[WIDTH-1:0]), .dout(quot_fix)
    );
    mdu_cneg #(.WIDTH(WIDTH)) u_fix_rem (
        .en(neg_hi_q), .din(acc_q[2*WIDTH-1:WIDTH]), .dout(rem_fix)
    );
`else
    logic unused_op_div;
    assign unused_op_div = op_div;
`endif

    // NOTE: every variable gets a default first so no path can infer a latch.
    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        acc_d    = acc_q;
        opnd_d   = opnd_q;
        neg_lo_d = neg_lo_q;
        busy_d   = 1'b0;
        done_d   = 1'b0;
        hi_d     = hi_q;
        lo_d     = lo_q;
`ifdef MDU_DIV_EN
        op_div_d = op_div_q;
        neg_hi_d = neg_hi_q;
        dz_d     = dz_q;
        a_raw_d  = a_raw_q;
`endif

        case (state_q)
            ST_IDLE: begin
                if (hi_we) hi_d = wr_data;
                if (lo_we) lo_d = wr_data;
                if (start) begin
                    state_d  = ST_CALC;
                    count_d  = '0;
                    acc_d    = {{(WIDTH+1){1'b0}}, a_mag};
                    opnd_d   = b_mag;
                    neg_lo_d = a_neg ^ b_neg;
`ifdef MDU_DIV_EN
                    op_div_d = op_div;
                    neg_hi_d = (op_div == OP_DIV) ? a_neg : (a_neg ^ b_neg);
                    dz_d     = (b_in == '0);
                    a_raw_d  = a_in;
`endif
                end
            end

            ST_CALC: begin
                busy_d = 1'b1;
                if (count_q == LAST_STEP) begin
                    state_d = ST_FIX;
                end else begin
                    count_d = count_q + CW'(1);
`ifdef MDU_DIV_EN
                    acc_d = (op_div_q == OP_DIV) ? div_next : mul_next;
`else
                    acc_d = mul_next;
`endif
                end
            end

            ST_FIX: begin
                state_d = ST_IDLE;
                done_d  = 1'b1;
`ifdef MDU_DIV_EN
                if (op_div_q == OP_DIV) begin
                    if (dz_q) begin
                        lo_d = DIVZERO_QUOT;
                        hi_d = a_raw_q;
                    end else begin
                        lo_d = quot_fix;
                        hi_d = rem_fix;
                    end
                end else begin
                    {hi_d, lo_d} = prod_fix;
                end
`else
                {hi_d, lo_d} = prod_fix;
`endif
            end

            default: state_d = ST_IDLE;
        endcase

        // Abort wins over FIX completion: results and done are suppressed.
        if (abort && (state_q != ST_IDLE)) begin
            state_d = ST_IDLE;
            busy_d  = 1'b0;
            done_d  = 1'b0;
            hi_d    = hi_q;
            lo_d    = lo_q;
        end
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            count_q  <= '0;
            acc_q    <= '0;
            opnd_q   <= '0;
            neg_lo_q <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            hi_q     <= '0;
            lo_q     <= '0;
`ifdef MDU_DIV_EN
            op_div_q <= OP_MUL;
            neg_hi_q <= 1'b0;
            dz_q     <= 1'b0;
            a_raw_q  <= '0;
`endif
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            acc_q    <= acc_d;
            opnd_q   <= opnd_d;
            neg_lo_q <= neg_lo_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
`ifdef MDU_DIV_EN
            op_div_q <= op_div_d;
            neg_hi_q <= neg_hi_d;
            dz_q     <= dz_d;
            a_raw_q  <= a_raw_d;
`endif
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// Directed self-checking bench for mult_div_unit (WIDTH=32); divide vectors are used when MDU_DIV_EN is defined.
module tb_mult_div_unit;

    logic        clk = 1'b0;
    logic        reset, start, op_div, op_sign, abort, hi_we, lo_we;
    logic [31:0] a_in, b_in, wr_data;
    logic        busy, done;
    logic [31:0] hi, lo;

    int checks = 0;
    int errors = 0;
    int cyc, bcnt, pulses;

    mult_div_unit #(.WIDTH(32)) dut (
        .clk(clk), .reset(reset), .start(start), .op_div(op_div), .op_sign(op_sign),
        .a_in(a_in), .b_in(b_in), .abort(abort), .hi_we(hi_we), .lo_we(lo_we),
        .wr_data(wr_data), .busy(busy), .done(done), .hi(hi), .lo(lo)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Called away from a rising edge; returns 1 time unit after the accepting edge.
    task automatic issue_start(input logic d, input logic s, input logic [31:0] a, input logic [31:0] b);
        start = 1'b1; op_div = d; op_sign = s; a_in = a; b_in = b;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    // Counts falling edges before done is seen; gives up after 100.
    task automatic wait_done(output int c, output int bc);
        c = 0; bc = 0;
        while (c < 100) begin
            @(negedge clk);
            if (done === 1'b1) break;
            if (busy === 1'b1) bc++;
            c++;
        end
    endtask

    task automatic count_dones(input int n, output int p);
        p = 0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (done === 1'b1) p++;
        end
    endtask

    task automatic run_op(input string tag, input logic d, input logic s,
                          input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp_hi, input logic [31:0] exp_lo);
        int c, bc;
        issue_start(d, s, a, b);
        wait_done(c, bc);
        check({tag, "_latency"}, 64'(c), 64'd34);
        check({tag, "_busy_cycles"}, 64'(bc), 64'd33);
        check({tag, "_hi"}, {32'h0, hi}, {32'h0, exp_hi});
        check({tag, "_lo"}, {32'h0, lo}, {32'h0, exp_lo});
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; op_div = 1'b0; op_sign = 1'b0; abort = 1'b0;
        hi_we = 1'b0; lo_we = 1'b0; a_in = '0; b_in = '0; wr_data = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset_busy", {63'h0, busy}, 64'd0);
        check("reset_done", {63'h0, done}, 64'd0);
        check("reset_hi", {32'h0, hi}, 64'd0);
        check("reset_lo", {32'h0, lo}, 64'd0);
        reset = 1'b0;

        // HI/LO writes in IDLE
        @(negedge clk);
        hi_we = 1'b1; wr_data = 32'h12345678;
        @(posedge clk);
        #1 hi_we = 1'b0;
        @(negedge clk);
        check("mthi_hi", {32'h0, hi}, 64'h12345678);
        check("mthi_lo_kept", {32'h0, lo}, 64'h0);
        lo_we = 1'b1; wr_data = 32'hCAFEF00D;
        @(posedge clk);
        #1 lo_we = 1'b0;
        @(negedge clk);
        check("mtlo_lo", {32'h0, lo}, 64'hCAFEF00D);

        // Abort at cycle 10 of CALC, with an mthi/mtlo attempt while busy
        issue_start(1'b0, 1'b0, 32'd1000, 32'd1000);
        repeat (2) @(negedge clk);
        hi_we = 1'b1; lo_we = 1'b1; wr_data = 32'hDEADBEEF;
        @(posedge clk);
        #1 begin hi_we = 1'b0; lo_we = 1'b0; end
        repeat (8) @(negedge clk);
        abort = 1'b1;
        @(posedge clk);
        #1 abort = 1'b0;
        @(negedge clk);
        check("abort_busy", {63'h0, busy}, 64'd0);
        check("abort_done", {63'h0, done}, 64'd0);
        check("abort_hi_kept", {32'h0, hi}, 64'h12345678);
        check("abort_lo_kept", {32'h0, lo}, 64'hCAFEF00D);
        count_dones(40, pulses);
        check("abort_no_done", 64'(pulses), 64'd0);

        // Multiply vectors
        run_op("umul_max", 1'b0, 1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001);
        @(negedge clk);
        check("done_one_cycle", {63'h0, done}, 64'd0);
        run_op("smul_m3x7", 1'b0, 1'b1, 32'hFFFFFFFD, 32'd7, 32'hFFFFFFFF, 32'hFFFFFFEB);
        run_op("umul_m3x7", 1'b0, 1'b0, 32'hFFFFFFFD, 32'd7, 32'h00000006, 32'hFFFFFFEB);
        run_op("smul_min2", 1'b0, 1'b1, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000);
        run_op("smul_m1m1", 1'b0, 1'b1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 32'h00000001);

`ifdef MDU_DIV_EN
        run_op("sdiv_m7_2", 1'b1, 1'b1, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD);
        run_op("udiv_7_2", 1'b1, 1'b0, 32'd7, 32'd2, 32'h00000001, 32'h00000003);
        run_op("sdiv_7_m2", 1'b1, 1'b1, 32'd7, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD);
        run_op("div_5_0", 1'b1, 1'b0, 32'd5, 32'd0, 32'h00000005, 32'hFFFFFFFF);
        run_op("sdiv_m5_0", 1'b1, 1'b1, 32'hFFFFFFFB, 32'd0, 32'hFFFFFFFB, 32'hFFFFFFFF);
        run_op("sdiv_min_m1", 1'b1, 1'b1, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000);
`else
        run_op("nodiv_7_2", 1'b1, 1'b0, 32'd7, 32'd2, 32'h00000000, 32'h0000000E);
        run_op("nodiv_sm7_2", 1'b1, 1'b1, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFF2);
`endif

        // Same-edge start and mthi: write lands, result overwrites later
        @(negedge clk);
        hi_we = 1'b1; wr_data = 32'hAAAA5555;
        issue_start(1'b0, 1'b0, 32'd9, 32'd9);
        hi_we = 1'b0;
        @(negedge clk);
        check("start_write_hi", {32'h0, hi}, 64'hAAAA5555);
        wait_done(cyc, bcnt);
        check("start_write_latency", 64'(cyc + 1), 64'd34);
        check("start_write_res_hi", {32'h0, hi}, 64'h0);
        check("start_write_res_lo", {32'h0, lo}, 64'd81);

        // Second start during CALC is neither taken nor queued
        @(negedge clk);
        issue_start(1'b0, 1'b0, 32'd3, 32'd5);
        repeat (5) @(negedge clk);
        start = 1'b1; op_sign = 1'b1; a_in = 32'd100; b_in = 32'd100;
        @(posedge clk);
        #1 start = 1'b0;
        wait_done(cyc, bcnt);
        check("restart_latency", 64'(cyc + 5), 64'd34);
        check("restart_hi", {32'h0, hi}, 64'h0);
        check("restart_lo", {32'h0, lo}, 64'd15);
        count_dones(40, pulses);
        check("restart_not_queued", 64'(pulses), 64'd0);

        // Reset in the middle of CALC
        issue_start(1'b0, 1'b0, 32'd11, 32'd13);
        repeat (5) @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check("midreset_busy", {63'h0, busy}, 64'd0);
        check("midreset_done", {63'h0, done}, 64'd0);
        check("midreset_hi", {32'h0, hi}, 64'd0);
        check("midreset_lo", {32'h0, lo}, 64'd0);
        count_dones(40, pulses);
        check("midreset_no_done", 64'(pulses), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
